// File: rtl/bus_arb_pkg.sv
// Shared types and constants for the two-master bus arbiter.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BUSY0 = 2'd1,
        ST_BUSY1 = 2'd2
    } state_t;

    localparam logic M0 = 1'b0;
    localparam logic M1 = 1'b1;

    localparam logic [31:0] ERR_RDATA = 32'h0;

endpackage

// File: rtl/bus_arbiter_rr_pick2.sv
// Two-way round-robin choice: on a tie, the master not served last wins.
module rr_pick2
    import bus_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_grant,
    output logic       o_valid
);

    always_comb begin
        o_valid = |i_req;
        o_grant = M0;
        case (i_req)
            2'b10:   o_grant = M1;
            2'b11:   o_grant = ~i_last_grant;
            default: o_grant = M0;
        endcase
    end

endmodule

// File: rtl/bus_arbiter.sv
// Two-master round-robin bus arbiter and transaction sequencer with watchdog.
module bus_arbiter
    import bus_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          cpu_clk,
    input  logic          cpu_rst_n,
    input  logic          m0_req,
    input  logic          m1_req,
    input  logic          m0_we,
    input  logic          m1_we,
    input  logic [AW-1:0] m0_addr,
    input  logic [AW-1:0] m1_addr,
    input  logic [DW-1:0] m0_wdata,
    input  logic [DW-1:0] m1_wdata,
    output logic          m0_ack,
    output logic          m1_ack,
    output logic [DW-1:0] m0_rdata,
    output logic [DW-1:0] m1_rdata,
    output logic          m0_err,
    output logic          m1_err,
    output logic          m0_stall,
    output logic [AW-1:0] Bus_addr,
    output logic          Bus_we,
    output logic [DW-1:0] Bus_wdata,
    output logic          Bus_req,
    input  logic [DW-1:0] Bus_rdata,
    input  logic          Bus_ack
);

    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t        r_state, w_state_nxt;
    logic          r_last_grant;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [AW-1:0] r_addr;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic          r_m0_ack, r_m1_ack, r_m0_err, r_m1_err;
    logic [DW-1:0] r_m0_rdata, r_m1_rdata;

    logic w_pick, w_pick_valid;
    logic w_busy, w_cur, w_tmo;
    logic w_start, w_done, w_err;

    rr_pick2 u_pick (
        .i_req       ({m1_req, m0_req}),
        .i_last_grant(r_last_grant),
        .o_grant     (w_pick),
        .o_valid     (w_pick_valid)
    );

    assign w_busy    = (r_state != ST_IDLE);
    assign w_cur     = (r_state == ST_BUSY1) ? M1 : M0;
    assign w_cnt_nxt = (r_cnt == '1) ? r_cnt : r_cnt + 1'b1;
    // Fires in the BUSY cycle whose closing edge would bring the count to TIMEOUT.
    assign w_tmo     = (TIMEOUT != 0) && (w_cnt_nxt == CW'(TIMEOUT));

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) r_state <= ST_IDLE;
        else            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_pick_valid) begin
                    w_start     = 1'b1;
                    w_state_nxt = (w_pick == M1) ? ST_BUSY1 : ST_BUSY0;
                end
            end
            ST_BUSY0, ST_BUSY1: begin
                if (Bus_ack) begin
                    w_done      = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (w_tmo) begin
                    w_done      = 1'b1;
                    w_err       = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            r_last_grant <= M1;
            r_cnt        <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_wdata      <= '0;
            r_m0_ack     <= 1'b0;
            r_m1_ack     <= 1'b0;
            r_m0_err     <= 1'b0;
            r_m1_err     <= 1'b0;
            r_m0_rdata   <= '0;
            r_m1_rdata   <= '0;
        end else begin
            if (w_start) begin
                r_addr  <= (w_pick == M1) ? m1_addr  : m0_addr;
                r_we    <= (w_pick == M1) ? m1_we    : m0_we;
                r_wdata <= (w_pick == M1) ? m1_wdata : m0_wdata;
                r_cnt   <= '0;
            end else if (w_busy) begin
                r_cnt   <= w_cnt_nxt;
            end
            r_m0_ack <= w_done && (w_cur == M0);
            r_m1_ack <= w_done && (w_cur == M1);
            r_m0_err <= w_done && w_err && (w_cur == M0);
            r_m1_err <= w_done && w_err && (w_cur == M1);
            if (w_done) begin
                r_last_grant <= w_cur;
                if (w_cur == M0) r_m0_rdata <= w_err ? DW'(ERR_RDATA) : Bus_rdata;
                else             r_m1_rdata <= w_err ? DW'(ERR_RDATA) : Bus_rdata;
            end
        end
    end

    assign Bus_req   = w_busy;
    assign Bus_we    = w_busy & r_we;
    assign Bus_addr  = w_busy ? r_addr  : '0;
    assign Bus_wdata = w_busy ? r_wdata : '0;

    assign m0_ack    = r_m0_ack;
    assign m1_ack    = r_m1_ack;
    assign m0_err    = r_m0_err;
    assign m1_err    = r_m1_err;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign m0_stall  = m0_req & ~r_m0_ack;

endmodule

// File: tb/tb_bus_arbiter.sv
// Randomized transaction-level bench for bus_arbiter against a reference model.
module tb_bus_arbiter;

    localparam int T = 4;

    logic        cpu_clk = 1'b0;
    logic        cpu_rst_n;
    logic        m0_req, m1_req, m0_we, m1_we;
    logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
    logic        m0_ack, m1_ack, m0_err, m1_err, m0_stall;
    logic [31:0] m0_rdata, m1_rdata;
    logic [31:0] Bus_addr, Bus_wdata, Bus_rdata;
    logic        Bus_we, Bus_req, Bus_ack;

    int checks = 0;
    int failures = 0;

    // reference model state
    int          last_g;
    logic [31:0] exp_rd [2];
    logic [31:0] a_addr [2];
    logic        a_we   [2];
    logic [31:0] a_wdata[2];
    logic [31:0] a_rdata[2];

    bus_arbiter #(.AW(32), .DW(32), .TIMEOUT(T)) dut (
        .cpu_clk  (cpu_clk),
        .cpu_rst_n(cpu_rst_n),
        .m0_req   (m0_req),
        .m1_req   (m1_req),
        .m0_we    (m0_we),
        .m1_we    (m1_we),
        .m0_addr  (m0_addr),
        .m1_addr  (m1_addr),
        .m0_wdata (m0_wdata),
        .m1_wdata (m1_wdata),
        .m0_ack   (m0_ack),
        .m1_ack   (m1_ack),
        .m0_rdata (m0_rdata),
        .m1_rdata (m1_rdata),
        .m0_err   (m0_err),
        .m1_err   (m1_err),
        .m0_stall (m0_stall),
        .Bus_addr (Bus_addr),
        .Bus_we   (Bus_we),
        .Bus_wdata(Bus_wdata),
        .Bus_req  (Bus_req),
        .Bus_rdata(Bus_rdata),
        .Bus_ack  (Bus_ack)
    );

    always #5 cpu_clk = ~cpu_clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic rand_xfer(input int m);
        a_addr[m]  = $urandom & 32'hFFFF_FFFC;
        a_we[m]    = 1'($urandom_range(0, 1));
        a_wdata[m] = $urandom;
        a_rdata[m] = $urandom;
    endtask

    task automatic drive_inputs();
        m0_addr = a_addr[0]; m0_we = a_we[0]; m0_wdata = a_wdata[0];
        m1_addr = a_addr[1]; m1_we = a_we[1]; m1_wdata = a_wdata[1];
    endtask

    // d = BUSY cycle in which the slave acks (1-based); 0 = slave never acks
    task automatic txn(input bit r0, input bit r1, input int d0, input int d1);
        bit pend[2];
        int w, d, n;
        bit e;
        @(negedge cpu_clk);
        chk("idle_busreq", Bus_req, 0);
        drive_inputs();
        m0_req = r0; m1_req = r1;
        pend[0] = r0; pend[1] = r1;
        while (pend[0] || pend[1]) begin
            if (pend[0] && pend[1]) w = 1 - last_g;
            else                    w = pend[1] ? 1 : 0;
            d = (w == 1) ? d1 : d0;
            e = (d == 0) || (d > T);
            n = e ? T : d;
            @(negedge cpu_clk);
            for (int i = 1; i <= n; i++) begin
                chk("busy_req",   Bus_req, 1);
                chk("busy_addr",  Bus_addr, a_addr[w]);
                chk("busy_we",    Bus_we, a_we[w]);
                chk("busy_wdata", Bus_wdata, a_wdata[w]);
                chk("busy_acks",  {m1_ack, m0_ack}, 0);
                chk("busy_stall", m0_stall, m0_req);
                Bus_ack   = (i == d);
                Bus_rdata = (i == d) ? a_rdata[w] : $urandom;
                // winner's inputs wander; the latched copy must hold
                if (w == 0) begin m0_wdata = $urandom; m0_addr = $urandom; m0_we = ~m0_we; end
                else        begin m1_wdata = $urandom; m1_addr = $urandom; m1_we = ~m1_we; end
                @(negedge cpu_clk);
            end
            Bus_ack   = 1'b0;
            Bus_rdata = $urandom;
            exp_rd[w] = e ? 32'h0 : a_rdata[w];
            chk("ack_win",   (w == 0) ? m0_ack : m1_ack, 1);
            chk("ack_other", (w == 0) ? m1_ack : m0_ack, 0);
            chk("err_win",   (w == 0) ? m0_err : m1_err, e);
            chk("err_other", (w == 0) ? m1_err : m0_err, 0);
            chk("rdata0",    m0_rdata, exp_rd[0]);
            chk("rdata1",    m1_rdata, exp_rd[1]);
            chk("ack_busreq", Bus_req, 0);
            chk("ack_buswe",  Bus_we, 0);
            chk("ack_busaddr", Bus_addr, 0);
            chk("ack_stall", m0_stall, m0_req & (w != 0));
            last_g  = w;
            pend[w] = 1'b0;
            if (w == 0) m0_req = 1'b0;
            else        m1_req = 1'b0;
        end
        @(negedge cpu_clk);
        chk("post_acks", {m1_ack, m0_ack}, 0);
        chk("post_busreq", Bus_req, 0);
        chk("post_rdata0", m0_rdata, exp_rd[0]);
        chk("post_rdata1", m1_rdata, exp_rd[1]);
    endtask

    initial begin
        cpu_rst_n = 1'b0;
        m0_req = 1'b1; m1_req = 1'b0;
        m0_we = 0; m1_we = 0; m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
        Bus_ack = 1'b0; Bus_rdata = 32'h0;
        last_g = 1; exp_rd[0] = 0; exp_rd[1] = 0;
        #2;
        chk("rst_busreq", Bus_req, 0);
        chk("rst_buswe", Bus_we, 0);
        chk("rst_busaddr", Bus_addr, 0);
        chk("rst_buswdata", Bus_wdata, 0);
        chk("rst_acks", {m1_ack, m0_ack, m1_err, m0_err}, 0);
        chk("rst_rdata", {m1_rdata, m0_rdata}, 0);
        chk("rst_stall_hi", m0_stall, 1);
        m0_req = 1'b0;
        #1 chk("rst_stall_lo", m0_stall, 0);
        @(negedge cpu_clk); @(negedge cpu_clk);
        cpu_rst_n = 1'b1;

        rand_xfer(0); rand_xfer(1);
        txn(1, 1, 1, 1);

        rand_xfer(0);
        a_addr[0] = 32'h0000_1000; a_we[0] = 1'b0; a_rdata[0] = 32'hCAFE_0001;
        txn(1, 0, 2, 0);

        rand_xfer(0); rand_xfer(1);
        txn(1, 1, 2, 1);

        rand_xfer(1);
        a_addr[1] = 32'h10; a_we[1] = 1'b1; a_wdata[1] = 32'h55AA_55AA;
        txn(0, 1, 0, 3);

        rand_xfer(0);
        txn(1, 0, 0, 0);

        rand_xfer(1);
        txn(0, 1, 0, T);

        for (int k = 0; k < 30; k++) begin
            int pat;
            pat = $urandom_range(1, 3);
            rand_xfer(0); rand_xfer(1);
            txn(pat[0], pat[1], $urandom_range(0, T + 2), $urandom_range(0, T + 2));
        end

        // reset in the middle of an m1 transaction
        rand_xfer(1);
        @(negedge cpu_clk);
        drive_inputs();
        m1_req = 1'b1;
        @(negedge cpu_clk);
        chk("mid_busreq", Bus_req, 1);
        @(negedge cpu_clk);
        #1 cpu_rst_n = 1'b0;
        #1;
        chk("mid_rst_busreq", Bus_req, 0);
        chk("mid_rst_buswe", Bus_we, 0);
        chk("mid_rst_ack", m1_ack, 0);
        m1_req = 1'b0;
        @(negedge cpu_clk);
        chk("mid_rst_ack2", m1_ack, 0);
        cpu_rst_n = 1'b1;
        last_g = 1; exp_rd[0] = 0; exp_rd[1] = 0;
        rand_xfer(0); rand_xfer(1);
        txn(1, 1, 1, 2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
